// File: rtl/neuron_seq_mac.sv
// Sequential multiply-accumulate neuron: LANES signed products per beat, BEATS beats per vector,
// bias added on the first beat, optional ReLU, then saturation to OUT_W with a held result.
module neuron_seq_mac #(
  parameter int IN_W  = 5,
  parameter int W_W   = 5,
  parameter int LANES = 4,
  parameter int BEATS = 3,
  parameter int OUT_W = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_data,
  input  logic [LANES*W_W-1:0]   w_data,
  input  logic [OUT_W-1:0]       bias,
  input  logic                   relu_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       result,
  output logic                   sat_flag
);

  localparam int PROD_W = IN_W + W_W;
  localparam int ACC_W  = IN_W + W_W + $clog2(LANES*BEATS) + 1;
  localparam int CMP_W  = ACC_W + OUT_W;
  localparam int CNT_W  = $clog2(BEATS+1);

  localparam logic signed [CMP_W-1:0] MAX_V = {{(CMP_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CMP_W-1:0] MIN_V = {{(CMP_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t                    state_reg;
  logic signed [ACC_W-1:0]   acc_reg;
  logic [CNT_W-1:0]          beat_cnt_reg;
  logic                      relu_reg;

  logic signed [PROD_W-1:0]  prod [LANES];
  logic signed [ACC_W-1:0]   beat_sum;
  logic signed [ACC_W-1:0]   acc_base;
  logic signed [ACC_W-1:0]   sum_next;
  logic signed [ACC_W-1:0]   final_v;
  logic signed [CMP_W-1:0]   final_x;
  logic                      relu_use;
  logic                      sat_hi;
  logic                      sat_lo;
  logic [OUT_W-1:0]          clamped;
  logic [CNT_W-1:0]          cnt_inc;
  logic                      last_beat;

  // Both operands widened to the full product width first so the extreme negative values multiply exactly.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign prod[gi] = PROD_W'($signed(in_data[gi*IN_W +: IN_W])) *
                      PROD_W'($signed(w_data[gi*W_W +: W_W]));
  end

  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      beat_sum = beat_sum + ACC_W'(prod[i]);
    end
    acc_base  = (state_reg == IDLE) ? ACC_W'($signed(bias)) : acc_reg;
    sum_next  = acc_base + beat_sum;
    relu_use  = (state_reg == IDLE) ? relu_en : relu_reg;
    final_v   = (relu_use && sum_next[ACC_W-1]) ? '0 : sum_next;
    final_x   = CMP_W'(final_v);
    sat_hi    = final_x > MAX_V;
    sat_lo    = final_x < MIN_V;
    clamped   = sat_hi ? MAX_V[OUT_W-1:0] : (sat_lo ? MIN_V[OUT_W-1:0] : final_x[OUT_W-1:0]);
    cnt_inc   = (state_reg == IDLE) ? CNT_W'(1) : beat_cnt_reg + 1'b1;
    last_beat = cnt_inc == CNT_W'(BEATS);
  end

  // Beats are only offered to the FSM through in_ready, so in_valid alone marks a transfer below.
  assign in_ready = rst_n && (state_reg != HOLD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      acc_reg      <= '0;
      beat_cnt_reg <= '0;
      relu_reg     <= 1'b0;
      out_valid    <= 1'b0;
      result       <= '0;
      sat_flag     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, ACCUM: begin
          if (in_valid) begin
            acc_reg <= sum_next;
            if (state_reg == IDLE) relu_reg <= relu_en;
            if (last_beat) begin
              result       <= clamped;
              sat_flag     <= sat_hi | sat_lo;
              out_valid    <= 1'b1;
              beat_cnt_reg <= '0;
              state_reg    <= HOLD;
            end else begin
              beat_cnt_reg <= cnt_inc;
              state_reg    <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
